// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 default timing constants and per-axis total helper
package vga_timing_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  localparam int CNT_W_DEF = 10;
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;
  function automatic int axis_total(timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction
endpackage

// File: rtl/timing_axis.sv
// timing_axis: one raster axis; wrap counter plus sync/active/last decode of its next count
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP = H_FP_DEF,
  parameter int SYNC = H_SYNC_DEF,
  parameter int BP = H_BP_DEF,
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         sync_nxt,
  output logic         active_nxt,
  output logic         last_nxt
);
  localparam timing_t T = '{ACTIVE, FP, SYNC, BP};
  localparam int TOTAL = axis_total(T);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);
  localparam int SYNC_LO = ACTIVE + FP;
  localparam int SYNC_HI = ACTIVE + FP + SYNC;
  if (TOTAL > 2 ** W) begin : g_width_check
    $error("timing_axis: counter width too small for axis total");
  end
  logic [W-1:0] nxt;
  assign wrap = inc & (count == LAST);
  // next count: clear wins, then wrap, then increment; flags decode this value so they align with the count
  always_comb begin
    nxt = clr ? '0 : wrap ? '0 : inc ? count + 1'b1 : count;
    sync_nxt = (32'(nxt) >= SYNC_LO) && (32'(nxt) < SYNC_HI);
    active_nxt = 32'(nxt) < ACTIVE;
    last_nxt = nxt == LAST;
  end
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= nxt;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with registered, count-aligned flags
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             restart,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_end
);
  logic h_wrap, h_sync, h_act, h_last, v_sync, v_act, v_last, started;
  timing_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(CNT_W)) u_h (
    .clk(clk), .rst_n(rst_n), .inc(en), .clr(restart), .count(h_count), .wrap(h_wrap),
    .sync_nxt(h_sync), .active_nxt(h_act), .last_nxt(h_last)
  );
  timing_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(CNT_W)) u_v (
    .clk(clk), .rst_n(rst_n), .inc(h_wrap), .clr(restart), .count(v_count), .wrap(),
    .sync_nxt(v_sync), .active_nxt(v_act), .last_nxt(v_last)
  );
  // flag registers; video_on is held low until the first tick or restart after reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      started <= 1'b0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
      video_on <= 1'b0;
      line_end <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      started <= started | en | restart;
      hsync <= h_sync ? HS_POL : ~HS_POL;
      vsync <= v_sync ? VS_POL : ~VS_POL;
      video_on <= h_act & v_act & (started | en | restart);
      line_end <= h_last;
      frame_end <= h_last & v_last;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default 640x480 and tiny inverted-polarity raster against a linear pixel-index model
module tb_vga_timing_gen;
  localparam int A_HT = 640 + 16 + 96 + 48;
  localparam int A_VT = 480 + 10 + 2 + 33;
  localparam int B_HT = 8 + 1 + 2 + 1;
  localparam int B_VT = 4 + 1 + 1 + 1;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, restart = 1'b0;
  logic [9:0] ha, va;
  logic [3:0] hb, vb;
  logic hsa, vsa, voa, lea, fea, hsb, vsb, vob, leb, feb;
  int n_asrt = 0, n_fail = 0, pa = 0, pb = 0, fcnt;
  bit st = 1'b0;
  string phase = "reset";
  always #5 clk = ~clk;
  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .h_count(ha), .v_count(va),
    .hsync(hsa), .vsync(vsa), .video_on(voa), .line_end(lea), .frame_end(fea)
  );
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .h_count(hb), .v_count(vb),
    .hsync(hsb), .vsync(vsb), .video_on(vob), .line_end(leb), .frame_end(feb)
  );
  task automatic ok(input string tag, input int act, input int exp);
    n_asrt++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic chk(input string tag, input int hc, vc, hs, vs, vo, le, fe, p,
                     input int h_a, h_f, h_s, h_b, v_a, v_f, v_s, v_b, hpol, vpol);
    int ht, vt, eh, ev;
    ht = h_a + h_f + h_s + h_b;
    vt = v_a + v_f + v_s + v_b;
    eh = p % ht;
    ev = p / ht;
    ok({tag, ".h_count"}, hc, eh);
    ok({tag, ".v_count"}, vc, ev);
    ok({tag, ".hsync"}, hs, (eh >= h_a + h_f && eh < h_a + h_f + h_s) ? hpol : 1 - hpol);
    ok({tag, ".vsync"}, vs, (ev >= v_a + v_f && ev < v_a + v_f + v_s) ? vpol : 1 - vpol);
    ok({tag, ".video_on"}, vo, (st && eh < h_a && ev < v_a) ? 1 : 0);
    ok({tag, ".line_end"}, le, (eh == ht - 1) ? 1 : 0);
    ok({tag, ".frame_end"}, fe, (eh == ht - 1 && ev == vt - 1) ? 1 : 0);
  endtask
  task automatic chk_all();
    chk({phase, "/A"}, int'(ha), int'(va), int'(hsa), int'(vsa), int'(voa), int'(lea), int'(fea), pa,
        640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
    chk({phase, "/B"}, int'(hb), int'(vb), int'(hsb), int'(vsb), int'(vob), int'(leb), int'(feb), pb,
        8, 1, 2, 1, 4, 1, 1, 1, 1, 1);
  endtask
  task automatic step(input bit e, input bit r);
    en = e;
    restart = r;
    @(posedge clk);
    if (r) begin
      pa = 0;
      pb = 0;
      st = 1'b1;
    end else if (e) begin
      pa = (pa + 1) % (A_HT * A_VT);
      pb = (pb + 1) % (B_HT * B_VT);
      st = 1'b1;
    end
    #1;
    chk_all();
  endtask
  initial begin
    @(posedge clk);
    #1;
    chk_all();
    #2;
    rst_n = 1'b1;
    phase = "idle";
    repeat (3) step(1'b0, 1'b0);
    phase = "run";
    fcnt = 0;
    for (int i = 0; i < 3 * B_HT * B_VT; i++) begin
      step(1'b1, 1'b0);
      if (feb) fcnt++;
    end
    ok("b_frame_end_count", fcnt, 3);
    phase = "seek700";
    for (int i = 0; i < 5000 && pa != 3 * A_HT + 700; i++) step(1'b1, 1'b0);
    ok("seek700.h", int'(ha), 700);
    ok("seek700.v", int'(va), 3);
    phase = "restart";
    step(1'b1, 1'b1);
    ok("restart.h", int'(ha), 0);
    ok("restart.v", int'(va), 0);
    ok("restart.video_on", int'(voa), 1);
    ok("restart.hsync", int'(hsa), 1);
    ok("restart.vsync", int'(vsa), 1);
    phase = "en1of4";
    fcnt = 0;
    for (int i = 0; i < 4 * B_HT * B_VT; i++) begin
      step(i % 4 == 3, 1'b0);
      if (feb) fcnt++;
    end
    ok("b_frame_end_1of4_cycles", fcnt, 4);
    ok("b_frame_len_h", int'(hb), 0);
    ok("b_frame_len_v", int'(vb), 0);
    phase = "random";
    for (int i = 0; i < 2000; i++) step(1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    phase = "seek123";
    for (int i = 0; i < 40000 && pa != 45 * A_HT + 123; i++) step(1'b1, 1'b0);
    ok("seek123.h", int'(ha), 123);
    ok("seek123.v", int'(va), 45);
    phase = "async_reset";
    #2;
    rst_n = 1'b0;
    pa = 0;
    pb = 0;
    st = 1'b0;
    #1;
    chk_all();
    @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;
    phase = "post_reset";
    repeat (3) step(1'b0, 1'b0);
    ok("post_reset.video_on_gated", int'(voa), 0);
    step(1'b1, 1'b0);
    ok("post_reset.video_on_first_en", int'(voa), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
